// File: rtl/fifo_upsizer.sv
// fifo_upsizer
// Drains WIDTH-bit words from a show-ahead FIFO and packs RATIO consecutive
// words into one RATIO*WIDTH-bit beat on a registered valid/ready stream.
// A flush closes a partial beat early, marking it with a word-keep mask and
// a last flag so packet tails are not held back.
//
// Ports:
//   clk_i        clock, all logic on the rising edge
//   rst_ni       synchronous active-low reset
//   fifo_data_i  FIFO head word, valid whenever fifo_empty_i=0
//   fifo_empty_i FIFO empty flag
//   fifo_rd_en_o pop of the FIFO head this cycle
//   flush_i      request to emit the accumulated partial beat
//   out_valid_o  output beat valid
//   out_ready_i  downstream accepts the beat
//   out_data_o   packed beat, word i at [i*WIDTH +: WIDTH], first word lowest
//   out_keep_o   bit i set when word i of the beat holds data
//   out_last_o   beat was closed by a flush
//   busy_o       words accumulated, beat pending, or flush pending
module fifo_upsizer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [WIDTH-1:0]         fifo_data_i,
    input  logic                     fifo_empty_i,
    output logic                     fifo_rd_en_o,
    input  logic                     flush_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [RATIO*WIDTH-1:0]   out_data_o,
    output logic [RATIO-1:0]         out_keep_o,
    output logic                     out_last_o,
    output logic                     busy_o
);

    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

    logic [CW-1:0]          cnt_reg;
    logic [RATIO*WIDTH-1:0] acc_reg;
    logic                   flush_pend_reg;
    logic                   out_valid_reg;
    logic [RATIO*WIDTH-1:0] out_data_reg;
    logic [RATIO-1:0]       out_keep_reg;
    logic                   out_last_reg;

    logic                   slot_free;
    logic                   flush_eff;
    logic                   cnt_full;
    logic                   take;
    logic                   close;
    logic [CW:0]            n_words;
    logic [RATIO*WIDTH-1:0] merged;
    logic [RATIO-1:0]       keep_next;

    assign slot_free = ~out_valid_reg | out_ready_i;
    assign flush_eff = flush_i | flush_pend_reg;
    assign cnt_full  = (cnt_reg == CNT_LAST);

    // Never pop a word that would join a beat unable to close: the last word
    // of a beat needs a free slot, and a flush waiting for the slot freezes
    // the accumulator so the flushed beat keeps its exact contents.
    // out_ready_i reaches this pop combinationally for full throughput.
    assign take = rst_ni & ~fifo_empty_i & (~cnt_full | slot_free)
                & ~(flush_eff & ~slot_free);

    // Flush-driven closes are gated by slot_free; a word-driven close on the
    // last word already implies it through take.
    assign close = slot_free & ((take & cnt_full)
                 | (flush_eff & ((cnt_reg != '0) | take)));

    assign n_words = {1'b0, cnt_reg} + (CW + 1)'(take);

    // Accumulator merged with the word popped this cycle. Slots at or above
    // cnt are still zero in acc_reg, so unused words of a beat come out zero.
    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_word
            assign merged[gi*WIDTH +: WIDTH] =
                (take && cnt_reg == CW'(gi)) ? fifo_data_i
                                             : acc_reg[gi*WIDTH +: WIDTH];
            assign keep_next[gi] = (n_words > (CW + 1)'(gi));
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_reg        <= '0;
            acc_reg        <= '0;
            flush_pend_reg <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_keep_reg   <= '0;
            out_last_reg   <= 1'b0;
        end else begin
            // A flush either resolves now (close, or nothing to emit) or
            // must wait for the output slot.
            flush_pend_reg <= flush_eff & ~slot_free;
            if (close) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= merged;
                out_keep_reg  <= keep_next;
                out_last_reg  <= flush_eff;
                cnt_reg       <= '0;
                acc_reg       <= '0;
            end else begin
                if (take) begin
                    acc_reg <= merged;
                    cnt_reg <= cnt_reg + CW'(1);
                end
                if (out_ready_i) begin
                    out_valid_reg <= 1'b0;
                end
            end
        end
    end

    assign fifo_rd_en_o = take;
    assign out_valid_o  = out_valid_reg;
    assign out_data_o   = out_data_reg;
    assign out_keep_o   = out_keep_reg;
    assign out_last_o   = out_last_reg;
    assign busy_o       = (cnt_reg != '0) | out_valid_reg | flush_pend_reg;

endmodule

// File: tb/tb_fifo_upsizer.sv
// Testbench for fifo_upsizer (WIDTH=8, RATIO=4). The FIFO is a queue in the
// bench; a queue-based model of the accumulator and output slot is checked
// every cycle, and every accepted beat is checked against the popped word
// stream in order.
module tb_fifo_upsizer;

    localparam int WIDTH = 8;
    localparam int RATIO = 4;

    logic                   clk_i;
    logic                   rst_ni;
    logic [WIDTH-1:0]       fifo_data_i;
    logic                   fifo_empty_i;
    logic                   fifo_rd_en_o;
    logic                   flush_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [RATIO*WIDTH-1:0] out_data_o;
    logic [RATIO-1:0]       out_keep_o;
    logic                   out_last_o;
    logic                   busy_o;

    fifo_upsizer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .fifo_data_i  (fifo_data_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rd_en_o (fifo_rd_en_o),
        .flush_i      (flush_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_keep_o   (out_keep_o),
        .out_last_o   (out_last_o),
        .busy_o       (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Environment FIFO and stream scoreboard
    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] sb[$];

    // Reference model state
    logic [WIDTH-1:0]       m_acc[$];
    logic                   m_valid = 1'b0;
    logic [RATIO*WIDTH-1:0] m_data  = '0;
    logic [RATIO-1:0]       m_keep  = '0;
    logic                   m_last  = 1'b0;
    logic                   m_pend  = 1'b0;

    int rd_count = 0;
    int beats    = 0;
    logic [RATIO*WIDTH-1:0] beat_data;
    logic [RATIO-1:0]       beat_keep;
    logic                   beat_last;

    task automatic tick();
        logic m_free, m_feff, m_take, m_close, dut_rd;
        int n;
        fifo_empty_i = (fq.size() == 0);
        fifo_data_i  = fifo_empty_i ? WIDTH'($urandom) : fq[0];
        @(negedge clk_i);
        m_free  = !m_valid || out_ready_i;
        m_feff  = flush_i || m_pend;
        m_take  = rst_ni && fq.size() > 0 && (m_acc.size() < RATIO - 1 || m_free)
                  && !(m_feff && !m_free);
        m_close = m_free && ((m_take && m_acc.size() == RATIO - 1)
                  || (m_feff && (m_acc.size() != 0 || m_take)));
        check_val("rd_en", 64'(fifo_rd_en_o), 64'(m_take));
        check_val("valid", 64'(out_valid_o), 64'(m_valid));
        check_val("data",  64'(out_data_o), 64'(m_data));
        check_val("keep",  64'(out_keep_o), 64'(m_keep));
        check_val("last",  64'(out_last_o), 64'(m_last));
        check_val("busy",  64'(busy_o),
                  64'(m_acc.size() != 0 || m_valid || m_pend));
        if (fifo_rd_en_o) rd_count++;
        if (out_valid_o && out_ready_i) begin
            $display("beat %0d: data=0x%08h keep=%b last=%0d", beats,
                     out_data_o, out_keep_o, out_last_o);
            beats++;
            beat_data = out_data_o;
            beat_keep = out_keep_o;
            beat_last = out_last_o;
            for (int i = 0; i < RATIO; i++) begin
                if (out_keep_o[i]) begin
                    if (sb.size() == 0) check_val("stream_extra", 64'(1), 64'(0));
                    else check_val("stream_word", 64'(out_data_o[i*WIDTH +: WIDTH]),
                                   64'(sb.pop_front()));
                end
            end
        end
        dut_rd = fifo_rd_en_o;
        @(posedge clk_i);
        if (!rst_ni) begin
            m_acc.delete();
            m_valid = 1'b0; m_data = '0; m_keep = '0; m_last = 1'b0; m_pend = 1'b0;
            sb.delete();
        end else begin
            if (m_take) m_acc.push_back(fq[0]);
            if (m_close) begin
                n = m_acc.size();
                m_data = '0;
                for (int i = 0; i < n; i++) m_data[i*WIDTH +: WIDTH] = m_acc[i];
                m_keep  = RATIO'((1 << n) - 1);
                m_last  = m_feff;
                m_valid = 1'b1;
                m_acc.delete();
            end else if (out_ready_i) begin
                m_valid = 1'b0;
            end
            m_pend = m_feff && !m_free;
            if (dut_rd && fq.size() > 0) begin
                sb.push_back(fq[0]);
                void'(fq.pop_front());
            end
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int b0;
        rst_ni = 1'b0; out_ready_i = 1'b1; flush_i = 1'b0;
        fifo_empty_i = 1'b1; fifo_data_i = '0;
        #1;
        ticks(2);
        check_val("rst_valid", 64'(out_valid_o), 64'(0));
        check_val("rst_busy",  64'(busy_o), 64'(0));
        rst_ni = 1'b1;

        // Single full beat
        rd_count = 0; b0 = beats;
        fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
        ticks(7);
        check_val("t1_reads", 64'(rd_count), 64'(4));
        check_val("t1_beats", 64'(beats - b0), 64'(1));
        check_val("t1_data",  64'(beat_data), 64'(32'h44332211));
        check_val("t1_keep",  64'(beat_keep), 64'(4'b1111));
        check_val("t1_last",  64'(beat_last), 64'(0));

        // Continuous stream
        b0 = beats;
        for (int i = 0; i < 16; i++) fq.push_back(8'(i));
        ticks(20);
        check_val("t2_beats", 64'(beats - b0), 64'(4));
        check_val("t2_data",  64'(beat_data), 64'(32'h0F0E0D0C));

        // Partial beat closed by flush
        fq.push_back(8'hA1); fq.push_back(8'hA2);
        ticks(3);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        ticks(3);
        check_val("t3_data", 64'(beat_data), 64'(32'h0000A2A1));
        check_val("t3_keep", 64'(beat_keep), 64'(4'b0011));
        check_val("t3_last", 64'(beat_last), 64'(1));
        check_val("t3_busy", 64'(busy_o), 64'(0));

        // Backpressure with 9 words, then a flush while the slot is held
        out_ready_i = 1'b0; rd_count = 0;
        for (int i = 0; i < 9; i++) fq.push_back(8'h30 + 8'(i));
        ticks(12);
        check_val("t4_reads", 64'(rd_count), 64'(7));
        check_val("t4_hold",  64'(out_data_o), 64'(32'h33323130));
        out_ready_i = 1'b1; ticks(1); out_ready_i = 1'b0;
        ticks(4);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        ticks(2);
        out_ready_i = 1'b1;
        ticks(8);
        check_val("t4_tail_keep", 64'(beat_keep), 64'(4'b0001));
        check_val("t4_tail_data", 64'(beat_data), 64'(32'h00000038));
        check_val("t4_fifo", 64'(fq.size()), 64'(0));

        // Reset mid-beat
        out_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) fq.push_back(8'hC0 + 8'(i));
        ticks(8);
        rst_ni = 1'b0; tick(); rst_ni = 1'b1;
        check_val("t5_valid", 64'(out_valid_o), 64'(0));
        check_val("t5_data",  64'(out_data_o), 64'(0));
        check_val("t5_busy",  64'(busy_o), 64'(0));
        out_ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) fq.push_back(8'(i));
        ticks(7);
        check_val("t5_beat", 64'(beat_data), 64'(32'h04030201));

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(2, 0) != 0 && fq.size() < 16) fq.push_back(8'($urandom));
            out_ready_i = ($urandom_range(3, 0) != 0);
            flush_i     = ($urandom_range(15, 0) == 0);
            tick();
        end
        out_ready_i = 1'b1; flush_i = 1'b0;
        ticks(24);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        ticks(6);
        check_val("drain_sb",   64'(sb.size()), 64'(0));
        check_val("drain_fifo", 64'(fq.size()), 64'(0));
        check_val("drain_busy", 64'(busy_o), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_upsizer.md
Name: fifo_upsizer

Overview:
Downstream consumer of the show-ahead FIFO. It drains WIDTH-bit words through the FIFO's empty/rd_en interface and packs RATIO consecutive words into one RATIO*WIDTH-bit beat. Beats leave on a registered valid/ready stream. A flush input emits a partial beat with a word-keep mask and a last flag, so packet tails are not held back.

Parameters:
WIDTH, 8, width of one FIFO word
RATIO, 4, FIFO words per output beat; legal values are 2 or more. Counter width is $clog2(RATIO).

Ports:
clk_i  input  1  clock; all logic on rising edge
rst_ni  input  1  reset, synchronous, active-low
fifo_data_i  input  WIDTH  show-ahead FIFO head word; valid whenever fifo_empty_i=0
fifo_empty_i  input  1  FIFO empty flag
fifo_rd_en_o  output  1  pop of the FIFO head this cycle
flush_i  input  1  request to emit the accumulated partial beat
out_valid_o  output  1  output beat valid
out_ready_i  input  1  downstream accepts the beat
out_data_o  output  RATIO*WIDTH  packed beat; word i is at bits [i*WIDTH +: WIDTH]
out_keep_o  output  RATIO  bit i=1 when word i of the beat holds data
out_last_o  output  1  beat was closed by a flush
busy_o  output  1  cnt!=0, or out_valid_o=1, or flush pending

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - out_valid_o, out_data_o, out_keep_o, out_last_o, word count cnt and flush pending are all cleared to 0.
  - fifo_rd_en_o is forced to 0 while rst_ni=0.
- Slot free: slot_free = ~out_valid_o | out_ready_i. The output register is a single stage.
- Close: close = (take and cnt==RATIO-1) | (flush_eff and (cnt!=0 or take)).
  - flush_eff = flush_i | flush pending.
- Read (combinational):
  - take = fifo_rd_en_o = ~fifo_empty_i & (cnt<RATIO-1 | slot_free) & ~(flush_eff & ~slot_free).
  - Do not read a word that would have to join a beat that cannot close.
  - There is a combinational path from out_ready_i to fifo_rd_en_o. This is deliberate: it gives full throughput.
- Accumulate:
  - On take, fifo_data_i is written into accumulator word cnt, and cnt increments.
  - The first word read goes to the least significant position.
- Close (requires slot_free, which is guaranteed by take and the flush gating):
  - The output register loads the accumulator merged with the word taken this cycle.
  - keep = (1<<n)-1, where n = words in the beat.
  - Unused words are driven to zero.
  - out_last_o = flush_eff.
  - cnt returns to 0, and the accumulator is zeroed.
- Full beat: a full RATIO-word beat with flush_eff=1 in the same cycle sets out_last_o=1, and keep is all ones.
- Flush with nothing to emit: flush_eff with cnt==0 and no take emits nothing. Flush pending clears and out_last_o is unaffected.
- Flush that cannot close: flush_i while ~slot_free sets flush pending. Flush pending clears on the cycle the partial beat closes.
- Output handshake:
  - out_valid_o clears when out_ready_i=1 and no new close occurs.
  - out_data_o, out_keep_o and out_last_o are stable while out_valid_o=1 and out_ready_i=0.
- Throughput: one beat per RATIO cycles when the FIFO is never empty and out_ready_i=1.
- Latency: a beat appears on out_valid_o in the cycle after its last word is read.
- FIFO empty mid-beat: the accumulator holds indefinitely. There is no timeout.
- Reset mid-beat: partial data and any pending beat are discarded. No output occurs after reset until new words arrive.

Test Plan:
- RATIO=4, WIDTH=8: push 0x11,0x22,0x33,0x44 with out_ready_i=1 -> one beat, out_data_o=0x44332211, keep=4'b1111, last=0, fifo_rd_en_o high for 4 consecutive cycles.
- Continuous stream 0x00..0x0F with out_ready_i=1 -> 4 beats on cycles 4,8,12,16 after the first read; values 0x03020100 ... 0x0F0E0D0C; no gaps.
- Words 0xA1,0xA2, then flush_i pulse with FIFO empty -> beat 0x0000A2A1, keep=4'b0011, last=1; busy_o drops to 0 the next cycle.
- Backpressure: out_ready_i=0 with 9 words queued -> first beat held stable; reads stop once cnt=3 (3 words accumulated); after out_ready_i=1 the remaining beats follow in order with no word lost or duplicated.
- flush_i while out_valid_o=1, out_ready_i=0, cnt=1 -> flush pending; no read; a partial beat with keep=4'b0001 is emitted after the held beat drains.
- rst_ni=0 for one cycle with cnt=2 and out_valid_o=1 -> all outputs 0 the next cycle; new words 0x01..0x04 produce beat 0x04030201.
